trigger_sequencer: RTL and testbench
====================================

Name: trigger_sequencer

Overview:
Programmable controller that sequences the tag's trigger strobe: it issues bursts or continuous trains of trigger pulses, with configurable start delay, pulse width and period. It replaces the free-running fixed trigger generator wherever backscatter modulation must be armed, counted and stopped under control of the host or FSM logic. Sits between the control/config logic and the modulation datapath's trigger input.

Parameters:
CNT_W, 16, width of delay/period/width counters (cycles)
BURST_W, 8, width of burst-count config and pulse index

Ports:
clock  input  1  system clock, all logic rising-edge
reset  input  1  asynchronous, active-low reset
start  input  1  1-cycle request to arm a run; sampled only in IDLE
stop  input  1  abort current run; level, sampled every cycle
mode  input  1  0 = finite burst of cfg_burst pulses, 1 = continuous until stop
cfg_delay  input  CNT_W  cycles from start acceptance to first rising edge (0 allowed)
cfg_width  input  CNT_W  trigger high time, cycles
cfg_period  input  CNT_W  rising-edge-to-rising-edge spacing, cycles
cfg_burst  input  BURST_W  pulses per run in mode 0
trigger_out  output  1  registered trigger strobe to datapath
busy  output  1  run in progress
done  output  1  1-cycle pulse when a mode-0 burst completes
cfg_err  output  1  1-cycle pulse when a start is rejected
burst_idx  output  BURST_W  pulses issued in current run

Behaviour:
- Reset (reset low, async): state IDLE; trigger_out=0, busy=0, done=0, cfg_err=0, burst_idx=0; all counters 0.
- States: IDLE, DELAY, HIGH, LOW.
- All config inputs latched into shadow registers on the accepted start edge; later config changes affect only the next run.
- Start validation in IDLE (edge N, start=1, stop=0): reject if cfg_width==0, cfg_width>=cfg_period, or (mode==0 and cfg_burst==0). Reject -> cfg_err=1 during cycle N+1 only, state stays IDLE, nothing else changes.
- Accepted start at edge N: busy=1 from cycle N+1; burst_idx cleared to 0. cfg_delay=D>0 -> DELAY for D cycles; first trigger_out rise at cycle N+1+D. D=0 -> trigger_out high in cycle N+1.
- HIGH: trigger_out=1 for exactly W=cfg_width cycles; burst_idx increments in the first HIGH cycle (value k shown while pulse k is high).
- LOW: trigger_out=0 for P-W cycles (P=cfg_period); next rise exactly P cycles after previous rise.
- Mode 0 end: after last pulse (burst_idx==cfg_burst) completes HIGH, no LOW phase: in the cycle after the last high cycle, done=1, busy=0, trigger_out=0, state IDLE. burst_idx holds final value until next accepted start.
- Mode 1: HIGH/LOW repeat indefinitely; burst_idx wraps modulo 2^BURST_W; done never asserts.
- stop=1 sampled in DELAY/HIGH/LOW: next cycle trigger_out=0, busy=0, state IDLE, no done. Truncated pulse allowed.
- stop and start same edge in IDLE: stop wins, start ignored, no cfg_err.
- start while busy: ignored, no cfg_err.
- Start on the same edge done is asserted (state just returned to IDLE) is accepted normally; back-to-back runs allowed.
- Counters: CNT_W-bit down-counters loaded with (value-1), phase advance at zero; no arithmetic overflow possible since W<P<=2^CNT_W-1.

Decomposition:
- Package trigger_pkg: state encoding constants (IDLE/DELAY/HIGH/LOW), default CNT_W/BURST_W, default config values (period 16'hFFFF, width 16'h000F).
- One sub-module: trigger_phase_counter (loadable CNT_W down-counter with load, enable, zero flag); single instance shared by DELAY/HIGH/LOW phases.

Test Plan:
- Reset mid-run: assert reset during HIGH -> trigger_out, busy, burst_idx go 0 immediately; no done after release.
- Mode 0, D=3, W=2, P=5, B=3, start at edge N -> rises at N+4, N+9, N+14; each high 2 cycles; done=1 and busy=0 at N+16; burst_idx=3.
- D=0, W=1, P=2, B=1 -> trigger_out high in N+1 only, done at N+2; immediate restart next cycle accepted.
- Invalid config: W=5, P=5 -> cfg_err pulse at N+1, busy stays 0; B=0 in mode 0 -> cfg_err.
- Mode 1, W=4, P=10: run 300 pulses with BURST_W=8 -> burst_idx wraps 255->0; assert stop in HIGH -> trigger_out 0 next cycle, no done.
- Config change while busy (P 10->20) -> period stays 10 until run ends; start pulses while busy ignored, no cfg_err.

Source files
------------

// File: rtl/trigger_pkg.sv
// Shared types and defaults for the trigger strobe sequencer.
package trigger_pkg;

  localparam int unsigned CNT_W_DEF   = 16;
  localparam int unsigned BURST_W_DEF = 8;

  // Shadow-register reset values; a valid pair so the idle config is sane.
  localparam logic [15:0] DEF_PERIOD = 16'hFFFF;
  localparam logic [15:0] DEF_WIDTH  = 16'h000F;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_HIGH  = 2'd2,
    ST_LOW   = 2'd3
  } state_t;

endpackage

// File: rtl/trigger_sequencer_if.sv
// Host/config side to sequencer bundle: run control, timing config and strobe/status.
interface trigger_sequencer_if
  import trigger_pkg::*;
#(
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned BURST_W = BURST_W_DEF
);
  logic               start;
  logic               stop;
  logic               mode;
  logic [CNT_W-1:0]   cfg_delay;
  logic [CNT_W-1:0]   cfg_width;
  logic [CNT_W-1:0]   cfg_period;
  logic [BURST_W-1:0] cfg_burst;
  logic               trigger_out;
  logic               busy;
  logic               done;
  logic               cfg_err;
  logic [BURST_W-1:0] burst_idx;

  modport master (
    output start, stop, mode, cfg_delay, cfg_width, cfg_period, cfg_burst,
    input  trigger_out, busy, done, cfg_err, burst_idx
  );

  modport slave (
    input  start, stop, mode, cfg_delay, cfg_width, cfg_period, cfg_burst,
    output trigger_out, busy, done, cfg_err, burst_idx
  );
endinterface

// File: rtl/trigger_phase_counter.sv
// Loadable down-counter timing the current DELAY/HIGH/LOW phase; parks at zero.
module trigger_phase_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero_c
);
  logic [CNT_W-1:0] count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero_c = (count == '0);
endmodule

// File: rtl/trigger_sequencer.sv
// Trigger strobe sequencer: delayed finite bursts or continuous pulse trains with abort.
module trigger_sequencer
  import trigger_pkg::*;
#(
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned BURST_W = BURST_W_DEF
) (
  input logic                clock,
  input logic                reset,
  trigger_sequencer_if.slave bus
);
  state_t             state;
  logic [CNT_W-1:0]   width_sh;
  logic [CNT_W-1:0]   period_sh;
  logic [BURST_W-1:0] burst_sh;
  logic               mode_sh;

  logic               trigger_q;
  logic               busy_q;
  logic               done_q;
  logic               cfg_err_q;
  logic [BURST_W-1:0] burst_idx_q;

  logic               cnt_zero_c;
  logic               load_c;
  logic               en_c;
  logic [CNT_W-1:0]   load_val_c;
  logic               req_c;
  logic               cfg_bad_c;
  logic               last_pulse_c;

  assign req_c        = bus.start && !bus.stop;
  assign cfg_bad_c    = (bus.cfg_width == '0) || (bus.cfg_width >= bus.cfg_period) ||
                        (!bus.mode && (bus.cfg_burst == '0));
  assign last_pulse_c = !mode_sh && (burst_idx_q == burst_sh);
  assign en_c         = (state != ST_IDLE);

  // Phase counter reload: every phase loads (length - 1) on the edge that enters it.
  always_comb begin
    load_c     = 1'b0;
    load_val_c = '0;
    unique case (state)
      ST_IDLE: begin
        if (req_c && !cfg_bad_c) begin
          load_c     = 1'b1;
          load_val_c = (bus.cfg_delay != '0) ? bus.cfg_delay - CNT_W'(1)
                                             : bus.cfg_width - CNT_W'(1);
        end
      end
      ST_DELAY, ST_LOW: begin
        if (!bus.stop && cnt_zero_c) begin
          load_c     = 1'b1;
          load_val_c = width_sh - CNT_W'(1);
        end
      end
      ST_HIGH: begin
        if (!bus.stop && cnt_zero_c && !last_pulse_c) begin
          load_c     = 1'b1;
          load_val_c = period_sh - width_sh - CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  trigger_phase_counter #(.CNT_W(CNT_W)) u_phase_cnt (
    .clock    (clock),
    .reset    (reset),
    .load     (load_c),
    .en       (en_c),
    .load_val (load_val_c),
    .zero_c   (cnt_zero_c)
  );

  // Run control FSM with registered strobe and status.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      trigger_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
      burst_idx_q <= '0;
      width_sh    <= CNT_W'(DEF_WIDTH);
      period_sh   <= CNT_W'(DEF_PERIOD);
      burst_sh    <= '0;
      mode_sh     <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      if (state == ST_IDLE) begin
        if (req_c) begin
          if (cfg_bad_c) begin
            cfg_err_q <= 1'b1;
          end else begin
            width_sh  <= bus.cfg_width;
            period_sh <= bus.cfg_period;
            burst_sh  <= bus.cfg_burst;
            mode_sh   <= bus.mode;
            busy_q    <= 1'b1;
            if (bus.cfg_delay != '0) begin
              state       <= ST_DELAY;
              burst_idx_q <= '0;
            end else begin
              state       <= ST_HIGH;
              trigger_q   <= 1'b1;
              burst_idx_q <= BURST_W'(1);
            end
          end
        end
      end else if (bus.stop) begin
        state     <= ST_IDLE;
        trigger_q <= 1'b0;
        busy_q    <= 1'b0;
      end else if (cnt_zero_c) begin
        unique case (state)
          ST_DELAY, ST_LOW: begin
            state       <= ST_HIGH;
            trigger_q   <= 1'b1;
            burst_idx_q <= burst_idx_q + BURST_W'(1);
          end
          ST_HIGH: begin
            trigger_q <= 1'b0;
            if (last_pulse_c) begin
              state  <= ST_IDLE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              state <= ST_LOW;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.trigger_out = trigger_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.cfg_err     = cfg_err_q;
  assign bus.burst_idx   = burst_idx_q;
endmodule

// File: tb/tb_trigger_sequencer.sv
// Randomised and directed bench for trigger_sequencer against a timeline-arithmetic model.
module tb_trigger_sequencer;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  trigger_sequencer_if #(.CNT_W(16), .BURST_W(8)) bus ();

  trigger_sequencer #(.CNT_W(16), .BURST_W(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  // Reference model: output of a run is a pure function of cycles elapsed since acceptance.
  logic       m_active, m_trig, m_busy, m_done, m_err;
  logic [7:0] m_idx;
  int         m_e, m_d, m_w, m_p, m_b;
  logic       m_mode;

  function automatic logic [8:0] cycle_out(int s, int w, int p);
    if (s < 0) return 9'd0;
    return {((s % p) < w), 8'((s / p) + 1)};
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_active <= 0; m_trig <= 0; m_busy <= 0; m_done <= 0; m_err <= 0;
      m_idx <= 0; m_e <= 0;
    end else begin
      m_done <= 0;
      m_err  <= 0;
      if (m_active) begin
        if (bus.stop) begin
          m_active <= 0; m_trig <= 0; m_busy <= 0;
        end else if (!m_mode && (m_e - m_d) >= (m_b - 1) * m_p + m_w) begin
          m_active <= 0; m_trig <= 0; m_busy <= 0; m_done <= 1;
        end else begin
          m_e <= m_e + 1;
          {m_trig, m_idx} <= cycle_out(m_e - m_d, m_w, m_p);
        end
      end else if (bus.start && !bus.stop) begin
        if (bus.cfg_width == 0 || bus.cfg_width >= bus.cfg_period ||
            (!bus.mode && bus.cfg_burst == 0)) begin
          m_err <= 1;
        end else begin
          m_active <= 1; m_busy <= 1; m_e <= 1;
          m_d <= int'(bus.cfg_delay); m_w <= int'(bus.cfg_width);
          m_p <= int'(bus.cfg_period); m_b <= int'(bus.cfg_burst);
          m_mode <= bus.mode;
          {m_trig, m_idx} <= cycle_out(-int'(bus.cfg_delay), int'(bus.cfg_width),
                                       int'(bus.cfg_period));
        end
      end
    end
  end

  logic [11:0] dut_vec, exp_vec;
  assign dut_vec = {bus.trigger_out, bus.busy, bus.done, bus.cfg_err, bus.burst_idx};
  assign exp_vec = {m_trig, m_busy, m_done, m_err, m_idx};

  task automatic drive_cfg(input int d, input int w, input int p, input int b, input logic md);
    bus.cfg_delay  = 16'(d);
    bus.cfg_width  = 16'(w);
    bus.cfg_period = 16'(p);
    bus.cfg_burst  = 8'(b);
    bus.mode       = md;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    checks++;
    if (dut_vec !== 12'h000) begin
      errors++;
      $display("FAIL reset_state got=%h exp=%h", dut_vec, 12'h000);
    end
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_burst();
    logic exp_t;
    drive_cfg(3, 2, 5, 3, 1'b0);
    bus.start = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      bus.start = 1'b0;
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++;
        $display("FAIL burst_model k=%0d got=%h exp=%h", k, dut_vec, exp_vec);
      end
      exp_t = (k inside {4, 5, 9, 10, 14, 15});
      checks++;
      if (bus.trigger_out !== exp_t) begin
        errors++;
        $display("FAIL burst_trigger k=%0d got=%b exp=%b", k, bus.trigger_out, exp_t);
      end
      if (k == 16) begin
        checks++;
        if ({bus.done, bus.busy, bus.burst_idx} !== {1'b1, 1'b0, 8'd3}) begin
          errors++;
          $display("FAIL burst_done got done=%b busy=%b idx=%0d exp done=1 busy=0 idx=3",
                   bus.done, bus.busy, bus.burst_idx);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    drive_cfg(0, 1, 2, 1, 1'b0);
    bus.start = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      bus.start = (k == 2);
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++;
        $display("FAIL b2b_model k=%0d got=%h exp=%h", k, dut_vec, exp_vec);
      end
      if (k == 1 || k == 3) begin
        checks++;
        if (bus.trigger_out !== 1'b1) begin
          errors++;
          $display("FAIL b2b_pulse k=%0d got=%b exp=1", k, bus.trigger_out);
        end
      end
      if (k == 2) begin
        checks++;
        if ({bus.done, bus.trigger_out} !== 2'b10) begin
          errors++;
          $display("FAIL b2b_done got done=%b trig=%b exp done=1 trig=0", bus.done, bus.trigger_out);
        end
      end
    end
  endtask

  task automatic test_invalid();
    int w[4]  = '{5, 0, 3, 2};
    int p[4]  = '{5, 8, 2, 6};
    int b[4]  = '{2, 2, 2, 0};
    for (int i = 0; i < 5; i++) begin
      if (i < 4) drive_cfg(1, w[i], p[i], b[i], 1'b0);
      else drive_cfg(1, 2, 6, 2, 1'b0);
      bus.start = 1'b1;
      bus.stop  = (i == 4);
      @(negedge clock);
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      checks++;
      if ({bus.cfg_err, bus.busy} !== {(i < 4), 1'b0}) begin
        errors++;
        $display("FAIL invalid_%0d got err=%b busy=%b exp err=%b busy=0", i, bus.cfg_err,
                 bus.busy, (i < 4));
      end
      @(negedge clock);
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++;
        $display("FAIL invalid_follow_%0d got=%h exp=%h", i, dut_vec, exp_vec);
      end
    end
  endtask

  task automatic test_continuous();
    logic [7:0] prev_idx = 8'd0;
    logic       saw_wrap = 1'b0;
    logic       found = 1'b0;
    drive_cfg(2, 4, 10, 0, 1'b1);
    bus.start = 1'b1;
    for (int k = 1; k <= 3010; k++) begin
      @(negedge clock);
      bus.start = 1'b0;
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++;
        $display("FAIL cont_model k=%0d got=%h exp=%h", k, dut_vec, exp_vec);
      end
      if (prev_idx == 8'd255 && bus.burst_idx == 8'd0) saw_wrap = 1'b1;
      prev_idx = bus.burst_idx;
    end
    checks++;
    if (saw_wrap !== 1'b1) begin
      errors++;
      $display("FAIL cont_wrap got=%b exp=1", saw_wrap);
    end
    for (int k = 0; k < 20 && !found; k++) begin
      if (bus.trigger_out === 1'b1) found = 1'b1;
      else @(negedge clock);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL cont_find_high got=0 exp=1");
    end
    bus.stop = 1'b1;
    @(negedge clock);
    bus.stop = 1'b0;
    checks++;
    if ({bus.trigger_out, bus.busy, bus.done} !== 3'b000 || dut_vec !== exp_vec) begin
      errors++;
      $display("FAIL cont_stop got=%h exp=%h", dut_vec, exp_vec);
    end
    @(negedge clock);
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL cont_no_done got=%b exp=0", bus.done);
    end
  endtask

  task automatic test_cfg_change();
    drive_cfg(0, 3, 10, 0, 1'b1);
    bus.start = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clock);
      bus.start = (k % 4 == 1);
      bus.cfg_period = 16'd20;
      checks++;
      if (dut_vec !== exp_vec || bus.cfg_err !== 1'b0) begin
        errors++;
        $display("FAIL cfgchg_model k=%0d got=%h exp=%h", k, dut_vec, exp_vec);
      end
      if (k == 11 || k == 21) begin
        checks++;
        if (bus.trigger_out !== 1'b1) begin
          errors++;
          $display("FAIL cfgchg_period k=%0d got=%b exp=1", k, bus.trigger_out);
        end
      end
    end
    bus.start = 1'b0;
    bus.stop  = 1'b1;
    @(negedge clock);
    bus.stop  = 1'b0;
    checks++;
    if (dut_vec !== exp_vec) begin
      errors++;
      $display("FAIL cfgchg_stop got=%h exp=%h", dut_vec, exp_vec);
    end
  endtask

  task automatic test_reset_mid_run();
    drive_cfg(0, 5, 8, 3, 1'b0);
    bus.start = 1'b1;
    repeat (2) @(negedge clock);
    bus.start = 1'b0;
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({bus.trigger_out, bus.busy, bus.burst_idx} !== 10'd0) begin
      errors++;
      $display("FAIL rst_mid got trig=%b busy=%b idx=%0d exp 0", bus.trigger_out, bus.busy,
               bus.burst_idx);
    end
    @(negedge clock);
    reset = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      checks++;
      if (dut_vec !== exp_vec || bus.done !== 1'b0) begin
        errors++;
        $display("FAIL rst_after k=%0d got=%h exp=%h", k, dut_vec, exp_vec);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 1500; k++) begin
      @(negedge clock);
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++;
        $display("FAIL random k=%0d got=%h exp=%h", k, dut_vec, exp_vec);
      end
      drive_cfg($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 8),
                $urandom_range(0, 4), ($urandom_range(0, 3) == 0));
      bus.start = ($urandom_range(0, 9) < 3);
      bus.stop  = ($urandom_range(0, 39) == 0);
    end
    bus.start = 1'b0;
    bus.stop  = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    drive_cfg(0, 0, 0, 0, 1'b0);
    test_reset();
    test_burst();
    test_back_to_back();
    repeat (3) @(negedge clock);
    test_invalid();
    test_continuous();
    test_cfg_change();
    test_reset_mid_run();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
